// File: rtl/pattern_rect_renderer.sv
// Rectangle-pattern renderer: double-buffers one pattern's 30 rectangles from the
// pattern ROM each frame and flags display pixels that fall inside any active rectangle.

module rect_hit #(
  parameter int X_W = 10,
  parameter int Y_W = 9,
  localparam int E_W = 2 * (X_W + Y_W)
) (
  input  logic [E_W-1:0] entry,
  input  logic [X_W-1:0] x,
  input  logic [Y_W-1:0] y,
  output logic           hit
);
  logic [X_W-1:0] x0, x1;
  logic [Y_W-1:0] y0, y1;

  assign {x0, y0, x1, y1} = entry;
  // Inverted bounds (x0>x1 or y0>y1) naturally fail the range test.
  assign hit = (|entry) && (x >= x0) && (x <= x1) && (y >= y0) && (y <= y1);
endmodule

module pattern_rect_renderer #(
  parameter int RECTS = 30,
  parameter int NPAT  = 8,
  parameter int X_W   = 10,
  parameter int Y_W   = 9,
  localparam int E_W   = 2 * (X_W + Y_W),
  localparam int IDX_W = $clog2(RECTS),
  localparam int PAT_W = $clog2(NPAT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [PAT_W-1:0] pattern_sel,
  input  logic [X_W-1:0]   x_pixel,
  input  logic [Y_W-1:0]   y_pixel,
  input  logic             DE,
  output logic             p_oe,
  output logic [7:0]       p_Addr,
  input  logic [E_W-1:0]   p_Data,
  output logic             pixel_on,
  output logic             busy,
  output logic [PAT_W-1:0] active_pat
);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(RECTS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [RECTS-1:0][E_W-1:0] shadow, active;
  logic [RECTS-1:0]          hit;
  logic [IDX_W-1:0]          rd_idx, cap_idx;
  logic                      cap_vld;
  logic [PAT_W-1:0]          sel_q;
  logic [7:0]                addr_q, base_c;
  logic                      swap;

  assign base_c = 8'(pattern_sel) * 8'(RECTS);
  assign p_Addr = addr_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // A frame_start in any state (re)starts the fetch; only an uninterrupted DRAIN swaps.
  always_comb begin
    state_nxt = state;
    p_oe      = 1'b0;
    busy      = 1'b0;
    swap      = 1'b0;
    case (state)
      IDLE:  if (frame_start) state_nxt = FETCH;
      FETCH: begin
        p_oe = 1'b1;
        busy = 1'b1;
        if (frame_start)         state_nxt = FETCH;
        else if (rd_idx == LAST) state_nxt = DRAIN;
      end
      DRAIN: begin
        busy      = 1'b1;
        swap      = !frame_start;
        state_nxt = frame_start ? FETCH : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sel_q      <= '0;
      addr_q     <= '0;
      rd_idx     <= '0;
      cap_vld    <= 1'b0;
      cap_idx    <= '0;
      shadow     <= '0;
      active     <= '0;
      active_pat <= '0;
      pixel_on   <= 1'b0;
    end else begin
      if (frame_start) begin
        sel_q  <= pattern_sel;
        addr_q <= base_c;
        rd_idx <= '0;
      end else if (p_oe && rd_idx != LAST) begin
        addr_q <= addr_q + 8'd1;
        rd_idx <= rd_idx + IDX_W'(1);
      end
      cap_vld <= p_oe;
      cap_idx <= rd_idx;
      if (cap_vld) shadow[cap_idx] <= p_Data;
      // The last word lands in the same edge as the swap, so bypass it into active.
      if (swap) begin
        for (int i = 0; i < RECTS; i++)
          active[i] <= (cap_vld && cap_idx == IDX_W'(i)) ? p_Data : shadow[i];
        active_pat <= sel_q;
      end
      pixel_on <= DE & (|hit);
    end
  end

  for (genvar g = 0; g < RECTS; g++) begin : g_rect
    rect_hit #(.X_W(X_W), .Y_W(Y_W)) u_hit (
      .entry (active[g]),
      .x     (x_pixel),
      .y     (y_pixel),
      .hit   (hit[g])
    );
  end
endmodule

// File: tb/tb_pattern_rect_renderer.sv
// Directed bench for pattern_rect_renderer with a registered-read pattern ROM model.

module tb_pattern_rect_renderer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        frame_start = 1'b0;
  logic [2:0]  pattern_sel = '0;
  logic [9:0]  x_pixel = '0;
  logic [8:0]  y_pixel = '0;
  logic        DE = 1'b0;
  logic        p_oe;
  logic [7:0]  p_Addr;
  logic [37:0] p_Data = '0;
  logic        pixel_on;
  logic        busy;
  logic [2:0]  active_pat;

  logic [37:0] rom [0:255];
  int checks = 0;
  int errors = 0;

  pattern_rect_renderer dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .pattern_sel(pattern_sel),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .DE(DE), .p_oe(p_oe), .p_Addr(p_Addr),
    .p_Data(p_Data), .pixel_on(pixel_on), .busy(busy), .active_pat(active_pat)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (p_oe) p_Data <= rom[p_Addr];

  function automatic logic [37:0] ent(input int x0, input int y0, input int x1, input int y1);
    return {10'(x0), 9'(y0), 10'(x1), 9'(y1)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called on a negedge; pulse is sampled on the next posedge, returns at negedge of cycle 1.
  task automatic start(input logic [2:0] sel);
    frame_start = 1'b1;
    pattern_sel = sel;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic track(input logic [7:0] base, input int ncyc, input logic [2:0] old_pat,
                       input logic [2:0] new_pat, input logic pix_old, input logic pix_new);
    for (int k = 1; k <= ncyc; k++) begin
      if (k > 1) @(negedge clk);
      chk("p_oe", p_oe, k <= 30);
      if (k <= 30) chk("p_Addr", p_Addr, base + 8'(k - 1));
      else         chk("p_Addr_hold", p_Addr, base + 8'd29);
      chk("busy", busy, k <= 31);
      chk("active_pat", active_pat, (k <= 31) ? old_pat : new_pat);
      chk("pixel_on_fetch", pixel_on, (k <= 32) ? pix_old : pix_new);
    end
  endtask

  task automatic pix(input int x, input int y, input logic de, input logic exp);
    x_pixel = 10'(x);
    y_pixel = 9'(y);
    DE      = de;
    @(negedge clk);
    chk("pixel_on", pixel_on, exp);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = '0;
    rom[0]   = ent(100, 50, 200, 80);
    rom[1]   = ent(300, 0, 10, 100);
    rom[60]  = ent(10, 10, 20, 20);
    rom[210] = ent(0, 0, 639, 479);

    repeat (3) @(negedge clk);
    chk("rst_p_oe", p_oe, 0);
    chk("rst_p_Addr", p_Addr, 0);
    chk("rst_pixel_on", pixel_on, 0);
    chk("rst_busy", busy, 0);
    chk("rst_active_pat", active_pat, 0);
    reset = 1'b1;
    x_pixel = '0; y_pixel = '0; DE = 1'b1;
    @(negedge clk);

    // Pattern 0 load
    start(3'd0);
    track(8'd0, 33, 3'd0, 3'd0, 1'b0, 1'b0);

    pix(100, 50, 1'b1, 1'b1);
    pix(200, 80, 1'b1, 1'b1);
    pix(150, 60, 1'b1, 1'b1);
    pix(99, 50, 1'b1, 1'b0);
    pix(201, 80, 1'b1, 1'b0);
    pix(150, 81, 1'b1, 1'b0);
    pix(150, 60, 1'b0, 1'b0);
    pix(0, 0, 1'b1, 1'b0);
    pix(300, 50, 1'b1, 1'b0);
    pix(10, 50, 1'b1, 1'b0);

    // Pattern 7: full-screen rectangle, old bank keeps (0,0) dark until swap
    pix(0, 0, 1'b1, 1'b0);
    start(3'd7);
    track(8'd210, 33, 3'd0, 3'd7, 1'b0, 1'b1);
    pix(640, 0, 1'b1, 1'b0);
    pix(639, 479, 1'b1, 1'b1);

    // Abort at cycle 10 and restart with pattern 2
    pix(0, 0, 1'b1, 1'b1);
    start(3'd0);
    track(8'd0, 10, 3'd7, 3'd7, 1'b1, 1'b1);
    start(3'd2);
    track(8'd60, 33, 3'd7, 3'd2, 1'b1, 1'b0);
    pix(15, 15, 1'b1, 1'b1);
    pix(150, 60, 1'b1, 1'b0);
    pix(21, 15, 1'b1, 1'b0);

    // Reset during fetch
    pix(0, 0, 1'b1, 1'b0);
    start(3'd7);
    track(8'd210, 15, 3'd2, 3'd2, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("midrst_p_oe", p_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_p_Addr", p_Addr, 0);
    chk("midrst_active_pat", active_pat, 0);
    chk("midrst_pixel_on", pixel_on, 0);
    @(negedge clk);
    reset = 1'b1;
    pix(15, 15, 1'b1, 1'b0);
    pix(0, 0, 1'b1, 1'b0);
    pix(639, 479, 1'b1, 1'b0);
    chk("post_rst_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pattern_rect_renderer.md
Name: pattern_rect_renderer

Overview:
- Consumer stage directly downstream of the 8-pattern rectangle ROM (30 entries per pattern, 38-bit entries, 1-cycle registered read).
- On each frame start, fetches all 30 rectangles of the selected pattern into a shadow register bank, then swaps the shadow bank into the active bank.
- For every displayed pixel, flags whether (x, y) falls inside any active rectangle.
- Output feeds the VGA colour mux.

Parameters:
- RECTS, 30, rectangles per pattern; also the ROM stride.
- NPAT, 8, number of patterns.
- X_W, 10, x coordinate width.
- Y_W, 9, y coordinate width.

Ports:
- clk  in  1  system/pixel clock
- reset  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse at the start of vertical blanking
- pattern_sel  in  3  pattern index; sampled only on frame_start
- x_pixel  in  10  current pixel x
- y_pixel  in  9  current pixel y
- DE  in  1  display enable
- p_oe  out  1  ROM read enable
- p_Addr  out  8  ROM address
- p_Data  in  38  ROM data, valid one cycle after p_oe/p_Addr
- pixel_on  out  1  registered; 1 = pixel inside an enabled active rectangle
- busy  out  1  high while a fetch is in progress
- active_pat  out  3  pattern index currently held in the active bank

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-low. While reset is low, all state clears:
  - outputs: p_oe=0, p_Addr=0, pixel_on=0, busy=0, active_pat=0.
  - both banks cleared to 0, so every rectangle is disabled.
  - FSM goes to IDLE.
- Entry format: [37:28] x0, [27:19] y0, [18:9] x1, [8:0] y1.
- Enable and hit rules:
  - An all-zero entry is disabled.
  - A non-zero entry with x0>x1 or y0>y1 matches no pixel.
  - Hit condition: x0<=x<=x1 and y0<=y<=y1, inclusive, unsigned compare.
- FSM states: IDLE, FETCH, DRAIN.
  - IDLE, frame_start=1:
    - latch sel=pattern_sel.
    - base = sel*30 (8-bit; maximum address 7*30+29 = 239).
    - rd_idx=0, go to FETCH.
  - FETCH, each cycle:
    - p_oe=1, p_Addr=base+rd_idx, rd_idx increments.
    - After the cycle with rd_idx=29 is issued, go to DRAIN.
  - DRAIN: one cycle; captures the final data word, then returns to IDLE.
  - Capture rule: in every cycle following an issued read, p_Data is written to shadow[wr_idx], with wr_idx = previous rd_idx (tracked by a 1-cycle delayed valid/index register).
  - Swap: on the DRAIN cycle's clock edge, after shadow[29] is written, active bank <= shadow bank and active_pat <= sel. The swap takes one cycle, is atomic, and happens 32 cycles after the frame_start cycle.
- busy: 1 from the cycle after frame_start through the DRAIN cycle inclusive (31 cycles).
- p_oe and p_Addr:
  - p_oe=0 outside FETCH.
  - p_Addr holds its last value when p_oe=0.
- frame_start while busy (FETCH or DRAIN):
  - abort and restart: re-latch pattern_sel, rd_idx=0, stay or enter FETCH.
  - no swap happens; the active bank is unchanged.
  - any in-flight capture still writes the shadow bank, which is harmless.
- Pixel path: 30 parallel comparators on the active bank, OR-reduced, ANDed with DE, registered.
  - Latency: pixel_on reflects x_pixel/y_pixel/DE from the previous cycle.
  - DE=0 forces pixel_on=0 on the next cycle.
  - The pixel path always reads the active bank, never the shadow bank, so no tearing occurs during a fetch.
- Reset asserted mid-fetch: immediate clear; no partial swap.

Test Plan:
- Reset, then frame_start with pattern_sel=0 → p_oe high for exactly 30 cycles; p_Addr steps 0..29; busy high 31 cycles; swap 32 cycles after frame_start; active_pat=0.
- pattern_sel=7 → p_Addr steps 210..239; active_pat=7 after the swap.
- Load entry {x0=100, y0=50, x1=200, y1=80} at index 0; drive DE=1:
  - (100,50), (200,80), (150,60) → pixel_on=1 one cycle later.
  - (99,50), (201,80), (150,81) → pixel_on=0.
- Same rectangle, (150,60) with DE=0 → pixel_on=0.
- All-zero entries: pixel (0,0) → pixel_on=0. Entry with x0=300, x1=10 → never hits.
- Second frame_start at cycle 10 of a fetch with pattern_sel=2:
  - no swap at the original time; p_Addr restarts at 60.
  - old active bank keeps driving pixel_on until the swap 32 cycles after the second pulse; active_pat then = 2.
- Reset low at cycle 15 of a fetch → p_oe=0, busy=0 immediately; pixel_on=0 for all pixels; active_pat=0.
